// File: rtl/mc_dbg_pkg.sv
// Shared types for the state-dump controller: FSM state encoding and beat tags.
package mc_dbg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StMemReq,
        StMemWait,
        StMemOut,
        StRegReq,
        StRegOut,
        StDone
    } dump_state_e;

    localparam logic TAG_MEM = 1'b0;
    localparam logic TAG_REG = 1'b1;

endpackage

// File: rtl/mc_dump_outreg.sv
// Valid/ready holding register for one dump beat (payload, tag, index).
module mc_dump_outreg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_tag,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_tag,
    output logic [IDX_W-1:0]  o_idx
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        // A held beat is never overwritten before it transfers.
        if (i_load && (!valid_q || i_ready)) begin
            valid_d = 1'b1;
            data_d  = i_data;
            tag_d   = i_tag;
            idx_d   = i_idx;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_tag   = tag_q;
    assign o_idx   = idx_q;

endmodule

// File: rtl/mc_state_dump_ctrl.sv
// PC-triggered snapshot engine: stalls the core, streams a memory window then the
// register file over a valid/ready port, and releases the core.
module mc_state_dump_ctrl
    import mc_dbg_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MEM_BASE = 256,
    parameter int unsigned MEM_END  = 512,
    parameter int unsigned MEM_STEP = 4,
    parameter int unsigned NREG     = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned REARM    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_arm,
    input  logic [ADDR_W-1:0]        i_trig_pc,
    input  logic [ADDR_W-1:0]        i_pc,
    output logic                     o_cpu_stall,
    output logic                     o_mem_rd,
    output logic [ADDR_W-1:0]        o_mem_addr,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic [$clog2(NREG)-1:0]  o_reg_addr,
    input  logic [DATA_W-1:0]        i_reg_rdata,
    output logic                     o_dump_valid,
    output logic [DATA_W-1:0]        o_dump_data,
    output logic                     o_dump_tag,
    output logic [ADDR_W-1:0]        o_dump_idx,
    input  logic                     i_dump_ready,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned RegAw   = $clog2(NREG);
    localparam int unsigned LatW    = $clog2(RD_LAT + 1);
    localparam bit          MemSkip = (MEM_BASE >= MEM_END);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RegAw-1:0]  reg_idx_q, reg_idx_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic              arm_pend_q, arm_pend_d;

    logic              win_last, lat_last, reg_last, beat_xfer, busy;
    logic              out_load, out_tag, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;

    // Window end compared one bit wider so the last step never wraps.
    assign win_last  = ({1'b0, addr_q} + (ADDR_W+1)'(MEM_STEP)) >= (ADDR_W+1)'(MEM_END);
    assign lat_last  = (lat_q == LatW'(RD_LAT - 1));
    assign reg_last  = (reg_idx_q == RegAw'(NREG - 1));
    assign beat_xfer = out_valid && i_dump_ready;
    assign busy      = (state_q != StIdle) && (state_q != StArmed);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (i_arm) state_d = StArmed;
            StArmed:   if (i_pc == i_trig_pc) state_d = MemSkip ? StRegReq : StMemReq;
            StMemReq:  state_d = StMemWait;
            StMemWait: if (lat_last) state_d = StMemOut;
            StMemOut:  if (beat_xfer) state_d = win_last ? StRegReq : StMemReq;
            StRegReq:  state_d = StRegOut;
            StRegOut:  if (beat_xfer) state_d = reg_last ? StDone : StRegReq;
            StDone:    state_d = (REARM != 0 || arm_pend_q || i_arm) ? StArmed : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        reg_idx_d  = reg_idx_q;
        lat_d      = lat_q;
        arm_pend_d = arm_pend_q;
        if (busy && i_arm) arm_pend_d = 1'b1;
        case (state_q)
            StArmed: begin
                addr_d    = ADDR_W'(MEM_BASE);
                reg_idx_d = '0;
            end
            StMemReq:  lat_d = '0;
            StMemWait: lat_d = lat_q + LatW'(1);
            StMemOut:  if (beat_xfer && !win_last) addr_d = addr_q + ADDR_W'(MEM_STEP);
            StRegOut:  if (beat_xfer && !reg_last) reg_idx_d = reg_idx_q + RegAw'(1);
            StDone:    arm_pend_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q     <= '0;
            reg_idx_q  <= '0;
            lat_q      <= '0;
            arm_pend_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            reg_idx_q  <= reg_idx_d;
            lat_q      <= lat_d;
            arm_pend_q <= arm_pend_d;
        end
    end

    always_comb begin
        o_mem_rd = 1'b0;
        o_done   = 1'b0;
        out_load = 1'b0;
        out_data = '0;
        out_tag  = TAG_MEM;
        out_idx  = '0;
        case (state_q)
            StMemReq:  o_mem_rd = 1'b1;
            StMemWait: begin
                if (lat_last) begin
                    out_load = 1'b1;
                    out_data = i_mem_rdata;
                    out_idx  = addr_q;
                end
            end
            StRegReq: begin
                out_load = 1'b1;
                out_data = i_reg_rdata;
                out_tag  = TAG_REG;
                out_idx  = ADDR_W'(reg_idx_q);
            end
            StDone:    o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_cpu_stall  = busy;
    assign o_busy       = busy;
    assign o_mem_addr   = addr_q;
    assign o_reg_addr   = reg_idx_q;
    assign o_dump_valid = out_valid;

    mc_dump_outreg #(
        .DATA_W(DATA_W),
        .IDX_W (ADDR_W)
    ) u_outreg (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (out_load),
        .i_data (out_data),
        .i_tag  (out_tag),
        .i_idx  (out_idx),
        .i_ready(i_dump_ready),
        .o_valid(out_valid),
        .o_data (o_dump_data),
        .o_tag  (o_dump_tag),
        .o_idx  (o_dump_idx)
    );

endmodule

// File: tb/tb_mc_state_dump_ctrl.sv
// Directed bench: four controller instances (defaults, RD_LAT=3 small window,
// empty window, self re-arming) share clock, reset, PC and sink ready.
module tb_mc_state_dump_ctrl;

    typedef struct packed {
        logic        tag;
        logic [31:0] idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] pc, trig_pc;
    logic        arm       [4];
    logic        stall     [4];
    logic        mem_rd    [4];
    logic        valid     [4];
    logic        tag       [4];
    logic        busy      [4];
    logic        done      [4];
    logic [31:0] mem_addr  [4];
    logic [31:0] rdata     [4];
    logic [31:0] dat       [4];
    logic [31:0] idx       [4];
    logic [31:0] reg_rdata [4];
    logic [4:0]  reg_addr  [4];

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE0000 ^ a;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned Lat = (g == 1) ? 3 : 1;
        logic [2:0]  rd_pipe;
        logic [31:0] a_pipe [3];

        // Memory returns real data only on the exact latency cycle, garbage otherwise.
        always @(posedge clk) begin
            rd_pipe   <= {rd_pipe[1:0], mem_rd[g]};
            a_pipe[0] <= mem_addr[g];
            a_pipe[1] <= a_pipe[0];
            a_pipe[2] <= a_pipe[1];
        end
        assign rdata[g]     = rd_pipe[Lat-1] ? memf(a_pipe[Lat-1]) : 32'hBAD0BAD0;
        assign reg_rdata[g] = 32'h5EE50000 | {27'd0, reg_addr[g]};

        mc_state_dump_ctrl #(
            .RD_LAT  (Lat),
            .MEM_BASE((g == 1) ? 32'h40 : 32'h100),
            .MEM_END ((g == 1) ? 32'h50 : (g == 2) ? 32'h100 : 32'h200),
            .REARM   ((g == 3) ? 1 : 0)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_arm       (arm[g]),
            .i_trig_pc   (trig_pc),
            .i_pc        (pc),
            .o_cpu_stall (stall[g]),
            .o_mem_rd    (mem_rd[g]),
            .o_mem_addr  (mem_addr[g]),
            .i_mem_rdata (rdata[g]),
            .o_reg_addr  (reg_addr[g]),
            .i_reg_rdata (reg_rdata[g]),
            .o_dump_valid(valid[g]),
            .o_dump_data (dat[g]),
            .o_dump_tag  (tag[g]),
            .o_dump_idx  (idx[g]),
            .i_dump_ready(ready),
            .o_busy      (busy[g]),
            .o_done      (done[g])
        );
    end

    function automatic beat_t exp_beat(input logic [31:0] base, input int nmem, input int i);
        logic [31:0] a;
        if (i < nmem) begin
            a = base + 32'(4 * i);
            return {1'b0, a, memf(a)};
        end
        a = 32'(i - nmem);
        return {1'b1, a, 32'h5EE50000 | a};
    endfunction

    function automatic int bad_beats(input logic [31:0] base, input int nmem);
        int bad = 0;
        for (int i = 0; i < q.size(); i++) if (q[i] !== exp_beat(base, nmem, i)) bad++;
        return bad;
    endfunction

    // Arm instance k with a non-matching PC, then present the match; returns in the
    // cycle after the match was sampled.
    task automatic fire(input int k);
        @(negedge clk);
        pc     = 32'h1234;
        arm[k] = 1'b1;
        @(negedge clk);
        arm[k] = 1'b0;
        pc     = 32'h0;
        @(negedge clk);
    endtask

    // Drives ready and records accepted beats until o_done (sampled at negedges).
    task automatic collect(input int k, input bit rnd, input int budget, output int ncyc,
                           output bit to, output int nrd, output int unstable);
        bit    hold, rdy;
        beat_t prev;
        q.delete();
        ncyc = 0; nrd = 0; unstable = 0; to = 1'b1; hold = 1'b0; prev = '0;
        for (int c = 0; c < budget; c++) begin
            if (done[k]) begin
                ncyc = c;
                to   = 1'b0;
                break;
            end
            if (hold && (!valid[k] || {tag[k], idx[k], dat[k]} != prev)) unstable++;
            if (mem_rd[k]) nrd++;
            rdy   = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
            ready = rdy;
            if (valid[k] && rdy) q.push_back({tag[k], idx[k], dat[k]});
            hold = valid[k] && !rdy;
            prev = {tag[k], idx[k], dat[k]};
            @(negedge clk);
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; pc = 32'h1234; trig_pc = 32'h0;
        for (int k = 0; k < 4; k++) arm[k] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({stall[k], busy[k], done[k], valid[k], mem_rd[k], tag[k]} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_ctrl[%0d]: got %b want 000000", k,
                         {stall[k], busy[k], done[k], valid[k], mem_rd[k], tag[k]});
            end
            n_cmp++;
            if ((mem_addr[k] | dat[k] | idx[k] | 32'(reg_addr[k])) !== 32'h0) begin
                n_err++;
                $display("FAIL reset_data[%0d]: got addr %0h data %0h idx %0h want 0", k,
                         mem_addr[k], dat[k], idx[k]);
            end
        end
    endtask

    task automatic test_single_dump();
        int ncyc, nrd, uns, bad;
        bit to;
        fire(0);
        n_cmp++;
        if ({stall[0], mem_rd[0]} !== 2'b11 || mem_addr[0] !== 32'h100) begin
            n_err++;
            $display("FAIL trigger_first_read: got stall/rd %b addr %0h want 11 100",
                     {stall[0], mem_rd[0]}, mem_addr[0]);
        end
        collect(0, 1'b0, 2000, ncyc, to, nrd, uns);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL dump1_timeout: got %0d want 0", to); end
        n_cmp++;
        if (ncyc !== 256) begin n_err++; $display("FAIL dump1_cycles: got %0d want 256", ncyc); end
        n_cmp++;
        if (nrd !== 64) begin n_err++; $display("FAIL dump1_reads: got %0d want 64", nrd); end
        n_cmp++;
        if (q.size() !== 96) begin
            n_err++;
            $display("FAIL dump1_beats: got %0d want 96", q.size());
        end
        bad = bad_beats(32'h100, 64);
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL dump1_payload: got %0d bad want 0", bad); end
        n_cmp++;
        if ({stall[0], busy[0], done[0]} !== 3'b111) begin
            n_err++;
            $display("FAIL done_cycle: got %b want 111", {stall[0], busy[0], done[0]});
        end
        @(negedge clk);
        n_cmp++;
        if ({stall[0], busy[0], done[0]} !== 3'b000) begin
            n_err++;
            $display("FAIL release: got %b want 000", {stall[0], busy[0], done[0]});
        end
    endtask

    task automatic test_ready_random();
        int ncyc, nrd, uns, bad, seen;
        bit to;
        // PC already matches: arm and match together only arm.
        @(negedge clk);
        arm[0] = 1'b1;
        @(negedge clk);
        arm[0] = 1'b0;
        n_cmp++;
        if (stall[0] !== 1'b0) begin n_err++; $display("FAIL arm_match_same: got %b want 0", stall[0]); end
        @(negedge clk);
        n_cmp++;
        if (stall[0] !== 1'b1) begin n_err++; $display("FAIL match_next: got %b want 1", stall[0]); end
        collect(0, 1'b1, 3000, ncyc, to, nrd, uns);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL rnd_timeout: got %0d want 0", to); end
        n_cmp++;
        if (uns !== 0) begin n_err++; $display("FAIL rnd_stability: got %0d want 0", uns); end
        n_cmp++;
        if (q.size() !== 96 || nrd !== 64) begin
            n_err++;
            $display("FAIL rnd_counts: got beats %0d reads %0d want 96 64", q.size(), nrd);
        end
        bad = bad_beats(32'h100, 64);
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL rnd_payload: got %0d bad want 0", bad); end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (stall[0] || busy[0] || mem_rd[0]) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL oneshot_ignore: got %0d want 0", seen); end
    endtask

    task automatic test_rd_latency();
        int ncyc, nrd, uns, bad;
        bit to;
        fire(1);
        n_cmp++;
        if (mem_rd[1] !== 1'b1 || mem_addr[1] !== 32'h40) begin
            n_err++;
            $display("FAIL lat_first_read: got %b %0h want 1 40", mem_rd[1], mem_addr[1]);
        end
        collect(1, 1'b0, 1000, ncyc, to, nrd, uns);
        n_cmp++;
        if (to !== 1'b0 || ncyc !== 84) begin
            n_err++;
            $display("FAIL lat_cycles: got to %0d cycles %0d want 0 84", to, ncyc);
        end
        n_cmp++;
        if (q.size() !== 36 || nrd !== 4) begin
            n_err++;
            $display("FAIL lat_counts: got beats %0d reads %0d want 36 4", q.size(), nrd);
        end
        bad = bad_beats(32'h40, 4);
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL lat_payload: got %0d bad want 0", bad); end
    endtask

    task automatic test_empty_window();
        int ncyc, nrd, uns, bad;
        bit to;
        fire(2);
        n_cmp++;
        if ({stall[2], mem_rd[2]} !== 2'b10) begin
            n_err++;
            $display("FAIL empty_start: got %b want 10", {stall[2], mem_rd[2]});
        end
        collect(2, 1'b0, 1000, ncyc, to, nrd, uns);
        n_cmp++;
        if (to !== 1'b0 || ncyc !== 64 || nrd !== 0) begin
            n_err++;
            $display("FAIL empty_cycles: got to %0d cycles %0d reads %0d want 0 64 0", to, ncyc, nrd);
        end
        bad = bad_beats(32'h100, 0);
        n_cmp++;
        if (q.size() !== 32 || bad !== 0) begin
            n_err++;
            $display("FAIL empty_beats: got %0d beats %0d bad want 32 0", q.size(), bad);
        end
    endtask

    task automatic test_reset_mid_dump();
        int ncyc, nrd, uns, beats, bad;
        bit to;
        fire(0);
        beats = 0;
        for (int c = 0; c < 500 && beats < 20; c++) begin
            if (valid[0]) beats++;
            if (beats < 20) @(negedge clk);
        end
        n_cmp++;
        if (beats !== 20) begin n_err++; $display("FAIL abort_reach: got %0d want 20", beats); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({stall[0], busy[0], valid[0], mem_rd[0], done[0]} !== 5'b0 ||
            (dat[0] | idx[0] | mem_addr[0]) !== 32'h0) begin
            n_err++;
            $display("FAIL abort_outputs: got ctrl %b data %0h idx %0h want 0",
                     {stall[0], busy[0], valid[0], mem_rd[0], done[0]}, dat[0], idx[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        fire(0);
        n_cmp++;
        if (mem_rd[0] !== 1'b1 || mem_addr[0] !== 32'h100) begin
            n_err++;
            $display("FAIL restart_addr: got %b %0h want 1 100", mem_rd[0], mem_addr[0]);
        end
        collect(0, 1'b0, 2000, ncyc, to, nrd, uns);
        bad = bad_beats(32'h100, 64);
        n_cmp++;
        if (to !== 1'b0 || q.size() !== 96 || bad !== 0) begin
            n_err++;
            $display("FAIL restart_dump: got to %0d beats %0d bad %0d want 0 96 0", to, q.size(), bad);
        end
    endtask

    task automatic test_arm_mid_dump();
        int ncyc, nrd, uns, bad, seen;
        bit to;
        fire(0);
        @(negedge clk);
        arm[0] = 1'b1;
        @(negedge clk);
        arm[0] = 1'b0;
        collect(0, 1'b0, 2000, ncyc, to, nrd, uns);
        n_cmp++;
        if (to !== 1'b0 || q.size() !== 96) begin
            n_err++;
            $display("FAIL midarm_first: got to %0d beats %0d want 0 96", to, q.size());
        end
        @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL midarm_armed: got %b want 0", busy[0]); end
        @(negedge clk);
        n_cmp++;
        if ({stall[0], mem_rd[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL midarm_retrig: got %b want 11", {stall[0], mem_rd[0]});
        end
        collect(0, 1'b0, 2000, ncyc, to, nrd, uns);
        bad = bad_beats(32'h100, 64);
        n_cmp++;
        if (to !== 1'b0 || q.size() !== 96 || bad !== 0) begin
            n_err++;
            $display("FAIL midarm_second: got to %0d beats %0d bad %0d want 0 96 0", to, q.size(), bad);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (stall[0] || busy[0]) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL midarm_cleared: got %0d want 0", seen); end
    endtask

    task automatic test_rearm();
        int ncyc, nrd, uns, bad;
        bit to;
        fire(3);
        collect(3, 1'b0, 2000, ncyc, to, nrd, uns);
        n_cmp++;
        if (to !== 1'b0 || q.size() !== 96) begin
            n_err++;
            $display("FAIL rearm_first: got to %0d beats %0d want 0 96", to, q.size());
        end
        @(negedge clk);
        n_cmp++;
        if ({stall[3], busy[3]} !== 2'b00) begin
            n_err++;
            $display("FAIL rearm_armed: got %b want 00", {stall[3], busy[3]});
        end
        @(negedge clk);
        n_cmp++;
        if ({stall[3], mem_rd[3]} !== 2'b11 || mem_addr[3] !== 32'h100) begin
            n_err++;
            $display("FAIL rearm_retrig: got %b %0h want 11 100", {stall[3], mem_rd[3]}, mem_addr[3]);
        end
        collect(3, 1'b0, 2000, ncyc, to, nrd, uns);
        pc = 32'h1234;
        bad = bad_beats(32'h100, 64);
        n_cmp++;
        if (to !== 1'b0 || q.size() !== 96 || bad !== 0) begin
            n_err++;
            $display("FAIL rearm_second: got to %0d beats %0d bad %0d want 0 96 0", to, q.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_dump();
        test_ready_random();
        test_rd_latency();
        test_empty_window();
        test_reset_mid_dump();
        test_arm_mid_dump();
        test_rearm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
